// File: rtl/stn2tft_pkg.sv
`default_nettype none
// stn2tft_pkg: shared state encoding, derived-constant helpers and counter sizing for the STN transmitter.
// Rev 1.0
package stn2tft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2
  } tx_state_e;

  localparam int H_DOTS_DEF  = 320;
  localparam int V_LINES_DEF = 240;
  localparam int HBLANK_DEF  = 8;
  localparam int VBLANK_DEF  = 2;

  localparam int BYTES_PER_LINE = H_DOTS_DEF / 8;
  localparam int LINE_PERIODS   = H_DOTS_DEF / 4 + HBLANK_DEF;
  localparam int FRAME_LINES    = V_LINES_DEF + VBLANK_DEF;

  function automatic int bytes_per_line(input int h_dots);
    return h_dots / 8;
  endfunction

  function automatic int line_periods(input int h_dots, input int hblank);
    return h_dots / 4 + hblank;
  endfunction

  function automatic int frame_lines(input int v_lines, input int vblank);
    return v_lines + vblank;
  endfunction

  // Bits needed for a counter running 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stn_tx_if.sv
`default_nettype none
// stn_tx_if: single-port frame-buffer read bus between the STN transmitter and its RAM.
// Rev 1.0
interface stn_tx_if #(
  parameter int ADDR_W = 14
);
  logic              ram_ce;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;

  modport master (output ram_ce, output ram_addr, input ram_rdata);
  modport slave  (input ram_ce, input ram_addr, output ram_rdata);
endinterface
`default_nettype wire

// File: rtl/stn_tx_timing.sv
`default_nettype none
// stn_tx_timing: clk divider, period and line counters; exports the counter values of the coming cycle.
// Rev 1.0
module stn_tx_timing
  import stn2tft_pkg::*;
#(
  parameter int H_DOTS    = 320,
  parameter int V_LINES   = 240,
  parameter int HBLANK    = 8,
  parameter int VBLANK    = 2,
  parameter int SHIFT_DIV = 4,
  localparam int DW = cnt_w(SHIFT_DIV),
  localparam int PW = cnt_w(line_periods(H_DOTS, HBLANK)),
  localparam int LW = cnt_w(frame_lines(V_LINES, VBLANK))
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          i_en,
  output logic          o_run,
  output logic          o_lead,
  output logic          o_load,
  output tx_state_e     o_state,
  output logic [DW-1:0] o_div,
  output logic [PW-1:0] o_per,
  output logic [LW-1:0] o_line
);
  localparam logic [DW-1:0] c_d_last = DW'(SHIFT_DIV - 1);
  localparam logic [PW-1:0] c_p_last = PW'(line_periods(H_DOTS, HBLANK) - 1);
  localparam logic [PW-1:0] c_p_act  = PW'(H_DOTS / 4);
  localparam logic [LW-1:0] c_l_last = LW'(frame_lines(V_LINES, VBLANK) - 1);

  tx_state_e     r_state, w_state;
  logic [DW-1:0] r_div, w_div;
  logic [PW-1:0] r_per, w_per;
  logic [LW-1:0] r_line, w_line;
  logic          r_lead, w_lead;
  logic          r_cont, w_cont;
  logic          w_load;

  // The lead-in after IDLE reuses the last HBLANK period of the last line, flagged by r_lead.
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_per   = r_per;
    w_line  = r_line;
    w_lead  = r_lead;
    w_cont  = r_cont;
    w_load  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_en) begin
        w_state = ST_HBLANK;
        w_per   = c_p_last;
        w_line  = c_l_last;
        w_lead  = 1'b1;
        w_cont  = 1'b1;
        w_load  = 1'b1;
      end
    end else if (r_div != c_d_last) begin
      w_div = r_div + 1'b1;
    end else begin
      w_div = '0;
      if (r_per == c_p_last) begin
        w_per   = '0;
        w_state = ST_ACTIVE;
        w_lead  = 1'b0;
        if (r_lead) begin
          w_line = '0;
        end else if (r_line != c_l_last) begin
          w_line = r_line + 1'b1;
        end else if (r_cont) begin
          w_line = '0;
        end else begin
          w_state = ST_IDLE;
          w_line  = '0;
          w_cont  = 1'b0;
        end
      end else begin
        w_per   = r_per + 1'b1;
        w_state = (w_per < c_p_act) ? ST_ACTIVE : ST_HBLANK;
        // Frame continuation and the next start address are decided entering the final period.
        if (!r_lead && (r_line == c_l_last) && (w_per == c_p_last)) begin
          w_cont = i_en;
          w_load = i_en;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_per   <= '0;
      r_line  <= '0;
      r_lead  <= 1'b0;
      r_cont  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_per   <= w_per;
      r_line  <= w_line;
      r_lead  <= w_lead;
      r_cont  <= w_cont;
    end
  end

  assign o_run   = (w_state != ST_IDLE);
  assign o_lead  = w_lead;
  assign o_load  = w_load;
  assign o_state = w_state;
  assign o_div   = w_div;
  assign o_per   = w_per;
  assign o_line  = w_line;

endmodule
`default_nettype wire

// File: rtl/stn_tx.sv
`default_nettype none
// stn_tx: STN panel transmitter streaming a 1-bpp frame buffer as 4-bit shifts with line/frame pulses.
// Rev 1.0
module stn_tx
  import stn2tft_pkg::*;
#(
  parameter int H_DOTS    = 320,
  parameter int V_LINES   = 240,
  parameter int HBLANK    = 8,
  parameter int VBLANK    = 2,
  parameter int LP_W      = 2,
  parameter int SHIFT_DIV = 4,
  parameter int ADDR_W    = 14
) (
  input  logic              clk,
  input  logic              rst_x,
  input  logic              en,
  input  logic [ADDR_W-1:0] sad,
  output logic              busy,
  stn_tx_if.master          ram,
  output logic              stn_fpframe,
  output logic              stn_fpline,
  output logic              stn_fpshift,
  output logic [3:0]        stn_fpdat
);
  localparam int DW = cnt_w(SHIFT_DIV);
  localparam int PW = cnt_w(line_periods(H_DOTS, HBLANK));
  localparam int LW = cnt_w(frame_lines(V_LINES, VBLANK));

  localparam logic [DW-1:0] c_d_half  = DW'(SHIFT_DIV / 2);
  localparam logic [DW-1:0] c_d_pref  = DW'(2);
  localparam logic [PW-1:0] c_p_last  = PW'(line_periods(H_DOTS, HBLANK) - 1);
  localparam logic [PW-1:0] c_p_fend  = PW'(2 * bytes_per_line(H_DOTS) - 1);
  localparam logic [PW-1:0] c_p_lp0   = PW'(H_DOTS / 4 + 1);
  localparam logic [PW-1:0] c_p_lp1   = PW'(H_DOTS / 4 + LP_W);
  localparam logic [LW-1:0] c_l_last  = LW'(frame_lines(V_LINES, VBLANK) - 1);
  localparam logic [LW-1:0] c_l_vlast = LW'(V_LINES - 1);

  logic          w_run, w_lead, w_load;
  tx_state_e     w_nst;
  logic [DW-1:0] w_ndiv;
  logic [PW-1:0] w_nper;
  logic [LW-1:0] w_nline;

  stn_tx_timing #(
    .H_DOTS    (H_DOTS),
    .V_LINES   (V_LINES),
    .HBLANK    (HBLANK),
    .VBLANK    (VBLANK),
    .SHIFT_DIV (SHIFT_DIV)
  ) u_timing (
    .clk     (clk),
    .rst_x   (rst_x),
    .i_en    (en),
    .o_run   (w_run),
    .o_lead  (w_lead),
    .o_load  (w_load),
    .o_state (w_nst),
    .o_div   (w_ndiv),
    .o_per   (w_nper),
    .o_line  (w_nline)
  );

  logic              r_busy, r_ce, r_capt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_buf, r_shift;
  logic [3:0]        r_dat;
  logic              r_fpshift, r_fpline, r_fpframe;
  logic              w_vis, w_fetch, w_lpulse;
  logic [7:0]        w_src;

  assign w_vis    = (w_nline <= c_l_vlast);
  assign w_lpulse = w_run && !w_lead && (w_nper >= c_p_lp0) && (w_nper <= c_p_lp1);
  // The lead-in prefetch lands exactly on the first ACTIVE edge, so bypass the byte buffer then.
  assign w_src    = r_capt ? ram.ram_rdata : r_buf;

  always_comb begin
    w_fetch = 1'b0;
    if (w_run) begin
      if (w_lead) begin
        w_fetch = (w_ndiv == c_d_pref);
      end else if (w_ndiv == '0) begin
        if (w_nper == c_p_last)
          w_fetch = (w_nline == c_l_last) ? w_load : (w_nline < c_l_vlast);
        else
          w_fetch = w_vis && w_nper[0] && (w_nper < c_p_fend);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_busy    <= 1'b0;
      r_ce      <= 1'b0;
      r_capt    <= 1'b0;
      r_addr    <= '0;
      r_buf     <= '0;
      r_shift   <= '0;
      r_dat     <= '0;
      r_fpshift <= 1'b0;
      r_fpline  <= 1'b0;
      r_fpframe <= 1'b0;
    end else begin
      r_busy    <= w_run;
      r_ce      <= w_fetch;
      r_capt    <= r_ce;
      r_fpshift <= w_run && (w_nst == ST_ACTIVE) && (w_ndiv < c_d_half);
      r_fpline  <= w_lpulse;
      r_fpframe <= w_lpulse && (w_nline == c_l_last);
      if (r_capt)
        r_buf <= ram.ram_rdata;
      if (w_load)
        r_addr <= sad;
      else if (r_ce)
        r_addr <= r_addr + 1'b1;
      if (!w_run) begin
        r_dat <= '0;
      end else if ((w_ndiv == '0) && !w_lead) begin
        if ((w_nst == ST_ACTIVE) && w_vis) begin
          if (!w_nper[0]) begin
            r_shift <= w_src;
            r_dat   <= w_src[7:4];
          end else begin
            r_dat <= r_shift[3:0];
          end
        end else begin
          r_dat <= '0;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign ram.ram_ce    = r_ce;
  assign ram.ram_addr  = r_addr;
  assign stn_fpshift   = r_fpshift;
  assign stn_fpline    = r_fpline;
  assign stn_fpframe   = r_fpframe;
  assign stn_fpdat     = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_stn_tx.sv
`default_nettype none
// tb_stn_tx: randomized scoreboard bench for stn_tx against a frame-level reference model.
// Rev 1.0
module tb_stn_tx;
  localparam int H_DOTS    = 16;
  localparam int V_LINES   = 4;
  localparam int HBLANK    = 4;
  localparam int VBLANK    = 1;
  localparam int LP_W      = 2;
  localparam int SHIFT_DIV = 4;
  localparam int ADDR_W    = 14;
  localparam int BPL       = H_DOTS / 8;
  localparam int FL        = V_LINES + VBLANK;
  localparam int LINE_CLK  = (H_DOTS / 4 + HBLANK) * SHIFT_DIV;
  localparam int FRAME_CLK = FL * LINE_CLK;

  logic              clk = 1'b0;
  logic              rst_x = 1'b0;
  logic              en = 1'b0;
  logic [ADDR_W-1:0] sad = '0;
  logic              busy, stn_fpframe, stn_fpline, stn_fpshift;
  logic [3:0]        stn_fpdat;

  stn_tx_if #(.ADDR_W(ADDR_W)) ram_if ();

  stn_tx #(
    .H_DOTS (H_DOTS), .V_LINES (V_LINES), .HBLANK (HBLANK), .VBLANK (VBLANK),
    .LP_W (LP_W), .SHIFT_DIV (SHIFT_DIV), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk), .rst_x (rst_x), .en (en), .sad (sad), .busy (busy),
    .ram (ram_if.master),
    .stn_fpframe (stn_fpframe), .stn_fpline (stn_fpline),
    .stn_fpshift (stn_fpshift), .stn_fpdat (stn_fpdat)
  );

  initial forever #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Synchronous RAM; outside the valid cycle the read bus carries junk.
  always @(posedge clk)
    ram_if.ram_rdata <= ram_if.ram_ce ? mem[ram_if.ram_addr] : 8'($urandom);

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] q_addr[$];
  logic [3:0]        q_nib[$];
  logic [1:0]        q_lev[$];   // [1] frame pulse expected, [0] follows previous line without gap

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-frame expectations from the frame buffer contents.
  task automatic push_frame(input logic [ADDR_W-1:0] s, input logic contig);
    logic [7:0]        b;
    logic [ADDR_W-1:0] a;
    for (int l = 0; l < FL; l++) begin
      q_lev.push_back({(l == FL - 1), ((l != 0) || contig)});
      for (int p = 0; p < H_DOTS / 4; p++) begin
        a = s + ADDR_W'(l * BPL + p / 2);
        b = (l < V_LINES) ? mem[a] : 8'h00;
        q_nib.push_back(p[0] ? b[3:0] : b[7:4]);
      end
    end
    for (int i = 0; i < V_LINES * BPL; i++)
      q_addr.push_back(s + ADDR_W'(i));
  endtask

  initial begin : monitor
    int   cyc, last_rise, lw, fw, hw;
    logic ps, pl;
    logic [1:0] lev;
    cyc = 0; last_rise = 0; lw = 0; fw = 0; hw = 0; ps = 1'b0; pl = 1'b0; lev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_x) begin
        ps = 1'b0; pl = 1'b0; lw = 0; fw = 0; hw = 0;
      end else begin
        if (ram_if.ram_ce) begin
          chk("ce_expected", (q_addr.size() != 0), 1);
          if (q_addr.size() != 0) chk("ram_addr", ram_if.ram_addr, q_addr.pop_front());
        end
        if (stn_fpshift && !ps) begin
          chk("nib_expected", (q_nib.size() != 0), 1);
          if (q_nib.size() != 0) chk("fpdat", stn_fpdat, q_nib.pop_front());
        end
        if (stn_fpshift) hw++;
        if (!stn_fpshift && ps) begin
          chk("shift_width", hw, SHIFT_DIV / 2);
          hw = 0;
        end
        if (stn_fpframe) chk("frame_in_line", stn_fpline, 1);
        if (stn_fpline) begin
          chk("hblank_quiet", {stn_fpshift, stn_fpdat}, 0);
          if (!pl) begin
            chk("line_expected", (q_lev.size() != 0), 1);
            if (q_lev.size() != 0) lev = q_lev.pop_front();
            if (lev[0]) chk("line_cadence", cyc - last_rise, LINE_CLK);
            last_rise = cyc;
          end
          lw++;
          if (stn_fpframe) fw++;
        end else if (pl) begin
          chk("line_width", lw, LP_W * SHIFT_DIV);
          chk("frame_width", fw, lev[1] ? LP_W * SHIFT_DIV : 0);
          lw = 0; fw = 0;
        end
        ps = stn_fpshift;
        pl = stn_fpline;
      end
    end
  end

  task automatic run(input int nfr, input logic [ADDR_W-1:0] s0, input logic [ADDR_W-1:0] s1);
    logic [ADDR_W-1:0] s;
    @(negedge clk);
    sad = s0; en = 1'b1;
    push_frame(s0, 1'b0);
    @(posedge clk); #1;
    chk("busy_rise", busy, 1);
    if (nfr == 1) en = 1'b0;
    sad = ADDR_W'($urandom);
    repeat (SHIFT_DIV - 1) @(posedge clk); #1;
    chk("lead_quiet", stn_fpshift, 0);
    @(posedge clk); #1;
    chk("active_start", stn_fpshift, 1);
    for (int f = 0; f < nfr; f++) begin
      repeat (FRAME_CLK / 2) @(posedge clk); #1;
      if (f < nfr - 1) begin
        s = (f == 0) ? s1 : ADDR_W'($urandom);
        sad = s;
        push_frame(s, 1'b1);
        repeat (FRAME_CLK / 2) @(posedge clk);
      end else begin
        en = 1'b0;
      end
    end
    repeat (FRAME_CLK / 2 - 1) @(posedge clk); #1;
    chk("busy_hold", busy, 1);
    @(posedge clk); #1;
    chk("busy_drop", busy, 0);
    repeat (4) @(posedge clk); #1;
    chk("addr_drained", q_addr.size(), 0);
    chk("nib_drained", q_nib.size(), 0);
    chk("line_drained", q_lev.size(), 0);
  endtask

  task automatic reset_mid_frame();
    logic [ADDR_W-1:0] s;
    s = ADDR_W'($urandom_range(16'h0100, 16'h3000));
    @(negedge clk);
    sad = s; en = 1'b1;
    push_frame(s, 1'b0);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (SHIFT_DIV + 2 * LINE_CLK + 2 * SHIFT_DIV) @(posedge clk); #1;
    chk("pre_reset_shift", stn_fpshift, 1);
    rst_x = 1'b0;
    #1;
    chk("reset_async", {busy, ram_if.ram_ce, ram_if.ram_addr, stn_fpframe, stn_fpline,
                        stn_fpshift, stn_fpdat}, 0);
    q_addr.delete(); q_nib.delete(); q_lev.delete();
    repeat (3) @(negedge clk);
    rst_x = 1'b1;
    sad = ADDR_W'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {busy, ram_if.ram_ce, stn_fpshift}, 0);
    end
  endtask

  initial begin : stim
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'hA5;
    mem[16'h0101] = 8'h3C;
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, ram_if.ram_ce, ram_if.ram_addr, stn_fpframe, stn_fpline,
                        stn_fpshift, stn_fpdat}, 0);
    rst_x = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sad = ADDR_W'($urandom);
      chk("idle_outputs", {busy, ram_if.ram_ce, ram_if.ram_addr, stn_fpframe, stn_fpline,
                           stn_fpshift, stn_fpdat}, 0);
    end
    run(1, 14'h0100, 14'h0000);
    run(1, 14'h3FFC, 14'h0000);
    run(2, 14'h0100, 14'h0200);
    for (int r = 0; r < 3; r++)
      run(1 + int'($urandom_range(0, 2)), ADDR_W'($urandom), ADDR_W'($urandom));
    reset_mid_frame();
    run(1, ADDR_W'($urandom), ADDR_W'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
